// File: rtl/exc_commit.sv
// Writeback-stage exception / ERTN commit controller: prioritises WB exceptions and
// interrupts, strobes the CSR file and runs the redirect handshake towards fetch.
module exc_commit #(
   parameter bit          INT_EN = 1'b1,
   parameter int unsigned ECNT_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              wb_valid,
   input  logic [31:0]       wb_pc_in,
   input  logic [31:0]       wb_vaddr_in,
   input  logic              wb_adef,
   input  logic              wb_ine,
   input  logic              wb_sys,
   input  logic              wb_brk,
   input  logic              wb_ale,
   input  logic              wb_ertn,
   input  logic              has_int,
   input  logic [31:0]       csr_eentry_data,
   input  logic [31:0]       csr_era_pc,
   input  logic              flush_ready,
   output logic              wb_ex,
   output logic [5:0]        wb_ecode,
   output logic [8:0]        wb_esubcode,
   output logic [31:0]       wb_pc,
   output logic [31:0]       wb_vaddr,
   output logic              ertn_flush,
   output logic              flush_valid,
   output logic [31:0]       flush_target,
   output logic              wb_commit,
   output logic [ECNT_W-1:0] exc_cnt
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t              state_q, state_d;
   logic                active_q;
   logic [31:0]         target_q, target_d;
   logic [ECNT_W-1:0]   cnt_q, cnt_d;
   logic                ev_valid, int_take, exc, ertn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         active_q <= 1'b0;
         state_q  <= IDLE;
         target_q <= '0;
         cnt_q    <= '0;
      end else begin
         active_q <= 1'b1;
         state_q  <= state_d;
         target_q <= target_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      int_take     = INT_EN & has_int;
      ev_valid     = active_q & (state_q == IDLE) & wb_valid;
      exc          = ev_valid & (int_take | wb_adef | wb_ine | wb_sys | wb_brk | wb_ale);
      ertn         = ev_valid & ~exc & wb_ertn;

      state_d      = state_q;
      target_d     = target_q;
      cnt_d        = cnt_q;
      wb_ex        = 1'b0;
      wb_ecode     = '0;
      wb_esubcode  = '0;
      wb_pc        = '0;
      wb_vaddr     = '0;
      ertn_flush   = 1'b0;
      flush_valid  = 1'b0;
      wb_commit    = ev_valid & ~exc & ~ertn;
      flush_target = active_q ? target_q : '0;
      exc_cnt      = active_q ? cnt_q : '0;

      if (exc) begin
         wb_ex    = 1'b1;
         wb_pc    = wb_pc_in;
         wb_vaddr = wb_vaddr_in;
         // Interrupt outranks synchronous faults; the instruction re-executes after return.
         if (int_take)     wb_ecode = 6'h00;
         else if (wb_adef) wb_ecode = 6'h08;
         else if (wb_ine)  wb_ecode = 6'h0D;
         else if (wb_sys)  wb_ecode = 6'h0B;
         else if (wb_brk)  wb_ecode = 6'h0C;
         else              wb_ecode = 6'h09;
         target_d = csr_eentry_data;
         cnt_d    = (&cnt_q) ? cnt_q : cnt_q + ECNT_W'(1);
         state_d  = REDIRECT;
      end else if (ertn) begin
         ertn_flush = 1'b1;
         target_d   = csr_era_pc;
         state_d    = REDIRECT;
      end

      if (active_q && state_q == REDIRECT) begin
         flush_valid = 1'b1;
         if (flush_ready) state_d = IDLE;
      end
   end

endmodule
